// File: rtl/mem_arbiter_if.sv
// Requester-side bundle for mem_arbiter: one instance per requester port.
// master = requester (fetch or load/store unit), slave = arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rvalid, rdata);
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter serialising fetch (p0) and load/store (p1) onto one synchronous memory.
// Optional macro MEMARB_FIXED_PRIORITY_EN: port 1 always wins ties (default is round-robin).
module mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  mem_arbiter_if.slave      p0,
  mem_arbiter_if.slave      p1,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_writeEnable,
  output logic [DATA_W-1:0] mem_dataIn,
  input  logic [DATA_W-1:0] mem_dataOut
);

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              cmd_we_q, cmd_we_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
  logic              cmd_port_q, cmd_port_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_port_q, rsp_port_d;
  logic              accept;
  logic              grant;

  assign accept = (state_q == IDLE) && (p0.req || p1.req);

  always_comb begin
    grant = 1'b0;
    if (p0.req && p1.req) begin
`ifdef MEMARB_FIXED_PRIORITY_EN
      grant = 1'b1;
`else
      grant = ~last_grant_q;
`endif
    end else if (p1.req) begin
      grant = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cmd_we_q     <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_wdata_q  <= '0;
      cmd_port_q   <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_port_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cmd_we_q     <= cmd_we_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_wdata_q  <= cmd_wdata_d;
      cmd_port_q   <= cmd_port_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_port_q   <= rsp_port_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Requests are only sampled in IDLE, so a req held through its ack cycle is not taken twice.
  always_comb begin
    last_grant_d = last_grant_q;
    cmd_we_d     = cmd_we_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_wdata_d  = cmd_wdata_q;
    cmd_port_d   = cmd_port_q;
    if (accept) begin
      last_grant_d = grant;
      cmd_port_d   = grant;
      cmd_we_d     = grant ? p1.we    : p0.we;
      cmd_addr_d   = grant ? p1.addr  : p0.addr;
      cmd_wdata_d  = grant ? p1.wdata : p0.wdata;
    end
    rsp_valid_d = (state_q == ISSUE) && !cmd_we_q;
    rsp_port_d  = cmd_port_q;
  end

  always_comb begin
    mem_address     = cmd_addr_q;
    mem_dataIn      = cmd_wdata_q;
    mem_writeEnable = (state_q == ISSUE) && cmd_we_q;
    p0.ack          = (state_q == ISSUE) && !cmd_port_q;
    p1.ack          = (state_q == ISSUE) &&  cmd_port_q;
    p0.rvalid       = rsp_valid_q && !rsp_port_q;
    p1.rvalid       = rsp_valid_q &&  rsp_port_q;
    p0.rdata        = mem_dataOut;
    p1.rdata        = mem_dataOut;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: drivers push expected acks/read data, a negedge monitor pops and checks.
// Build with MEMARB_FIXED_PRIORITY_EN defined to check the fixed-priority tie order instead of round-robin.
module tb_mem_arbiter;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  typedef struct {
    int          port;
    logic [31:0] data;
  } rsp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_writeEnable;
  logic [DATA_W-1:0] mem_dataIn;
  logic [DATA_W-1:0] mem_dataOut;
  logic [31:0]       mem [0:255];

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   ack_cnt [2];
  int   rvalid_cnt [2];
  int   last_rvalid_cyc [2];
  int   we_cycles = 0;
  int   exp_ack_q [$];
  rsp_t exp_rsp_q [$];
  int   ack_cyc_log [$];

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) p0_if ();
  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) p1_if ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .p0              (p0_if),
    .p1              (p1_if),
    .mem_address     (mem_address),
    .mem_writeEnable (mem_writeEnable),
    .mem_dataIn      (mem_dataIn),
    .mem_dataOut     (mem_dataOut)
  );

  always #5 clk = ~clk;

  // Single-port synchronous memory: registered read, read-before-write, no reset.
  always @(posedge clk) begin
    mem_dataOut <= mem[mem_address];
    if (mem_writeEnable) mem[mem_address] <= mem_dataIn;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic setPort(input int port, input logic req, input logic we,
                         input logic [7:0] addr, input logic [31:0] wdata);
    if (port == 0) begin
      p0_if.req = req; p0_if.we = we; p0_if.addr = addr; p0_if.wdata = wdata;
    end else begin
      p1_if.req = req; p1_if.we = we; p1_if.addr = addr; p1_if.wdata = wdata;
    end
  endtask

  function automatic logic getAck(input int port);
    return (port == 0) ? p0_if.ack : p1_if.ack;
  endfunction

  // Holds req until 'count' acks arrive (bounded), optionally queueing the expected results first.
  task automatic applyStimulus(input int port, input logic we, input logic [7:0] addr,
                               input logic [31:0] wdata, input int count,
                               input logic [31:0] exp_rdata, input bit push_exp,
                               output int req_cyc, output int ack_cyc);
    int   got;
    int   waited;
    rsp_t r;
    got = 0;
    waited = 0;
    ack_cyc = -1;
    @(negedge clk);
    if (push_exp) begin
      for (int k = 0; k < count; k++) begin
        exp_ack_q.push_back(port);
        if (!we) begin
          r.port = port;
          r.data = exp_rdata;
          exp_rsp_q.push_back(r);
        end
      end
    end
    setPort(port, 1'b1, we, addr, wdata);
    req_cyc = cyc;
    while (got < count && waited < 40) begin
      @(negedge clk);
      waited++;
      if (getAck(port)) begin
        got++;
        ack_cyc = cyc;
      end
    end
    setPort(port, 1'b0, 1'b0, 8'h00, 32'h0);
    checkOutput($sformatf("ack_count_p%0d", port), got, count);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: every ack and rvalid must match the head of its expectation queue.
  always @(negedge clk) begin : monitor
    int   port;
    rsp_t r;
    if (mem_writeEnable === 1'b1) we_cycles++;
    if (p0_if.ack === 1'b1 && p1_if.ack === 1'b1) checkOutput("dual_ack", 2, 1);
    if (p0_if.ack === 1'b1 || p1_if.ack === 1'b1) begin
      port = (p1_if.ack === 1'b1) ? 1 : 0;
      ack_cnt[port]++;
      ack_cyc_log.push_back(cyc);
      if (exp_ack_q.size() == 0) checkOutput($sformatf("unexpected_ack_p%0d", port), 1, 0);
      else checkOutput("ack_port", port, exp_ack_q.pop_front());
    end
    if (p0_if.rvalid === 1'b1 && p1_if.rvalid === 1'b1) checkOutput("dual_rvalid", 2, 1);
    if (p0_if.rvalid === 1'b1 || p1_if.rvalid === 1'b1) begin
      port = (p1_if.rvalid === 1'b1) ? 1 : 0;
      rvalid_cnt[port]++;
      last_rvalid_cyc[port] = cyc;
      if (exp_rsp_q.size() == 0) begin
        checkOutput($sformatf("unexpected_rvalid_p%0d", port), 1, 0);
      end else begin
        r = exp_rsp_q.pop_front();
        checkOutput("rvalid_port", port, r.port);
        checkOutput($sformatf("rdata_p%0d", port), (port == 0) ? p0_if.rdata : p1_if.rdata, r.data);
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   rc, ac, rc2, ac2;
    int   we0, a0, a1, r0, r1;
    rsp_t r;

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[1] = 32'h11;
    mem[2] = 32'h22;
    mem_dataOut = 32'h0;
    ack_cnt = '{0, 0};
    rvalid_cnt = '{0, 0};
    last_rvalid_cyc = '{0, 0};
    setPort(0, 1'b0, 1'b0, 8'h00, 32'h0);
    setPort(1, 1'b0, 1'b0, 8'h00, 32'h0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    @(negedge clk);
    checkOutput("rst_mem_address", mem_address, 0);
    checkOutput("rst_mem_dataIn", mem_dataIn, 0);
    checkOutput("rst_mem_we", mem_writeEnable, 0);
    checkOutput("rst_p0_ack", p0_if.ack, 0);
    checkOutput("rst_p1_ack", p1_if.ack, 0);
    checkOutput("rst_p0_rvalid", p0_if.rvalid, 0);
    checkOutput("rst_p1_rvalid", p1_if.rvalid, 0);

    $display("[TB] p0 write 0x10 then read back");
    applyStimulus(0, 1'b1, 8'h10, 32'hDEADBEEF, 1, 32'h0, 1'b1, rc, ac);
    checkOutput("wr_ack_latency", ac - rc, 1);
    applyStimulus(0, 1'b0, 8'h10, 32'h0, 1, 32'hDEADBEEF, 1'b1, rc, ac);
    checkOutput("rd_ack_latency", ac - rc, 1);
    repeat (3) @(negedge clk);
    checkOutput("rd_rvalid_latency", last_rvalid_cyc[0] - rc, 2);
    checkOutput("p1_ack_never", ack_cnt[1], 0);
    checkOutput("p1_rvalid_never", rvalid_cnt[1], 0);

    $display("[TB] both ports requesting reads continuously");
    doReset();
`ifdef MEMARB_FIXED_PRIORITY_EN
    exp_ack_q = '{1, 1, 0, 0};
    r.port = 1; r.data = 32'h22; exp_rsp_q.push_back(r); exp_rsp_q.push_back(r);
    r.port = 0; r.data = 32'h11; exp_rsp_q.push_back(r); exp_rsp_q.push_back(r);
`else
    exp_ack_q = '{0, 1, 0, 1};
    for (int k = 0; k < 2; k++) begin
      r.port = 0; r.data = 32'h11; exp_rsp_q.push_back(r);
      r.port = 1; r.data = 32'h22; exp_rsp_q.push_back(r);
    end
`endif
    a0 = ack_cnt[0];
    a1 = ack_cnt[1];
    ack_cyc_log.delete();
    fork
      applyStimulus(0, 1'b0, 8'h01, 32'h0, 2, 32'h11, 1'b0, rc, ac);
      applyStimulus(1, 1'b0, 8'h02, 32'h0, 2, 32'h22, 1'b0, rc2, ac2);
    join
    repeat (3) @(negedge clk);
    checkOutput("tie_p0_acks", ack_cnt[0] - a0, 2);
    checkOutput("tie_p1_acks", ack_cnt[1] - a1, 2);
    checkOutput("tie_ack_log_len", ack_cyc_log.size(), 4);
    for (int k = 1; k < ack_cyc_log.size(); k++)
      checkOutput("tie_ack_spacing", ack_cyc_log[k] - ack_cyc_log[k-1], 2);

    $display("[TB] p1 write 0x20 then p0 read 0x20");
    we0 = we_cycles;
    applyStimulus(1, 1'b1, 8'h20, 32'h5, 1, 32'h0, 1'b1, rc, ac);
    applyStimulus(0, 1'b0, 8'h20, 32'h0, 1, 32'h5, 1'b1, rc, ac);
    repeat (3) @(negedge clk);
    checkOutput("raw_we_cycles", we_cycles - we0, 1);
    checkOutput("raw_mem_content", mem[8'h20], 32'h5);

    $display("[TB] reset during ISSUE of a p0 read");
    r0 = rvalid_cnt[0];
    @(negedge clk);
    exp_ack_q.push_back(0);
    setPort(0, 1'b1, 1'b0, 8'h10, 32'h0);
    @(negedge clk);
    checkOutput("midrst_ack", p0_if.ack, 1);
    reset = 1'b1;
    setPort(0, 1'b0, 1'b0, 8'h00, 32'h0);
    @(negedge clk);
    checkOutput("midrst_p0_rvalid", p0_if.rvalid, 0);
    checkOutput("midrst_mem_address", mem_address, 0);
    checkOutput("midrst_mem_dataIn", mem_dataIn, 0);
    checkOutput("midrst_mem_we", mem_writeEnable, 0);
    checkOutput("midrst_p0_ack", p0_if.ack, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("midrst_no_rvalid", rvalid_cnt[0] - r0, 0);
    applyStimulus(0, 1'b0, 8'h10, 32'h0, 1, 32'hDEADBEEF, 1'b1, rc, ac);
    checkOutput("postrst_ack_latency", ac - rc, 1);
    repeat (3) @(negedge clk);
    checkOutput("postrst_rvalid_latency", last_rvalid_cyc[0] - rc, 2);

    $display("[TB] idle for 10 cycles");
    we0 = we_cycles;
    a0 = ack_cnt[0] + ack_cnt[1];
    r1 = rvalid_cnt[0] + rvalid_cnt[1];
    repeat (10) begin
      @(negedge clk);
      checkOutput("idle_mem_we", mem_writeEnable, 0);
    end
    checkOutput("idle_we_cycles", we_cycles - we0, 0);
    checkOutput("idle_acks", ack_cnt[0] + ack_cnt[1] - a0, 0);
    checkOutput("idle_rvalids", rvalid_cnt[0] + rvalid_cnt[1] - r1, 0);

    checkOutput("ack_queue_drained", exp_ack_q.size(), 0);
    checkOutput("rsp_queue_drained", exp_rsp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter in front of the CPU's single-port synchronous memory: 8-bit address, 32-bit data, one-cycle registered read, read-before-write.
- Port 0 is the instruction-fetch requester; port 1 is the load/store requester.
- Serialises their requests onto the one memory port, drives the memory's address/writeEnable/dataIn, and returns read data to the owning requester with a valid strobe.

Parameters:
- ADDR_W, 8, memory address width; must match the memory's addresswidth.
- DATA_W, 32, data width; must match the memory's width.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset, sampled on posedge clk.
- p0_req  in  1  port 0 request; held with p0_we/p0_addr/p0_wdata until p0_ack.
- p0_we  in  1  port 0: 1 = write, 0 = read.
- p0_addr  in  ADDR_W  port 0 address.
- p0_wdata  in  DATA_W  port 0 write data.
- p0_ack  out  1  one-cycle pulse: port 0 request has been issued to memory.
- p0_rvalid  out  1  one-cycle pulse: p0_rdata holds port 0 read result.
- p0_rdata  out  DATA_W  read data; qualified by p0_rvalid.
- p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_rvalid, p1_rdata: same as port 0, for port 1.
- mem_address  out  ADDR_W  to memory address.
- mem_writeEnable  out  1  to memory writeEnable.
- mem_dataIn  out  DATA_W  to memory dataIn.
- mem_dataOut  in  DATA_W  from memory dataOut.

Behaviour:
- FSM has two states.
  - IDLE: accepts a request.
  - ISSUE: latched command is driven to memory.
- IDLE, no req: stay IDLE.
  - mem_writeEnable = 0.
  - mem_address / mem_dataIn hold their last latched values.
- IDLE, any req at posedge: pick a winner (see arbitration).
  - Latch its we/addr/wdata and its port id into command registers.
  - Go to ISSUE.
- ISSUE (exactly one cycle):
  - mem_address = latched addr; mem_dataIn = latched wdata; mem_writeEnable = latched we.
  - Winner's ack = 1; loser's ack = 0.
  - Next state is always IDLE.
  - The memory captures the command at the posedge ending ISSUE.
- Read response: if the ISSUE command was a read, the winner's rvalid is 1 in the cycle after ISSUE.
  - rdata = mem_dataOut in that cycle.
  - Writes produce no rvalid.
- Timing summary:
  - req seen at edge E0.
  - ack during E0..E1.
  - rvalid during E1..E2.
  - Max throughput: one access per 2 cycles.
- Requester handshake:
  - Must keep req and fields stable until it sees ack.
  - May drop req, or present a new request, in the ack cycle.
  - The arbiter never samples req while in ISSUE, so a held req is not double-accepted.
- p0_rdata and p1_rdata are both wired to mem_dataOut; only the matching rvalid qualifies it.
- Arbitration, round-robin:
  - Register last_grant.
  - Both req high: grant the port != last_grant.
  - Single req: grant it.
  - last_grant updates on every accept.
- Read-after-write same address, back-to-back: the write lands at the end of its ISSUE, so the following read returns the new data.
- Reset values:
  - state = IDLE, last_grant = 1 (port 0 wins first tie).
  - Command registers 0, so mem_address = 0, mem_dataIn = 0, mem_writeEnable = 0.
  - p0/p1 ack = 0, p0/p1 rvalid = 0.
- Reset mid-operation:
  - Reset asserted during ISSUE: the memory still performs that edge's write (the memory has no reset).
  - The in-flight read response is dropped: rvalid stays 0 after reset.
  - Reset asserted in the rvalid cycle: rvalid pulse still seen that cycle; all outputs at reset values afterwards.

Optional Feature:
- Macro: MEMARB_FIXED_PRIORITY_EN.
- Defined: fixed priority; port 1 (data) always wins when both req are high. last_grant is still maintained but unused.
- Undefined: round-robin as above.

Test Plan:
- Reset, then p0 write addr 0x10 data 0xDEADBEEF; next request p0 read 0x10 -> p0_ack one cycle after req; p0_rvalid two cycles after read req; p0_rdata = 0xDEADBEEF; p1_ack and p1_rvalid never asserted.
- Both req high continuously, reads of 0x01 (p0) and 0x02 (p1), memory preloaded with 0x11/0x22 -> grants alternate p0, p1, p0, p1 at one ack every 2 cycles; each rvalid matches its own port and data (0x11 / 0x22).
- Same stimulus with MEMARB_FIXED_PRIORITY_EN defined -> p1 acked every accept; p0 starves until p1 drops req, then p0 is acked.
- p1 write 0x20 = 0x5, then immediately p0 read 0x20 -> p0_rdata = 0x5; mem_writeEnable high exactly one cycle.
- p0 read issued, reset asserted during ISSUE cycle -> no p0_rvalid afterwards; outputs zero; state IDLE; next p0 request after reset is accepted normally.
- Idle with no req for 10 cycles -> mem_writeEnable = 0 throughout; no ack or rvalid pulses.
